// File: rtl/uart_txq_pkg.sv
// Shared UART register map, status bits and queue FSM states.
// Imported by the transmit queue and its FIFO.
package uart_defs;

  localparam logic [31:0] UART_CTRL   = 32'h0000_0000;
  localparam logic [31:0] UART_STATUS = 32'h0000_0004;
  localparam logic [31:0] UART_BAUD   = 32'h0000_0008;
  localparam logic [31:0] UART_TXDATA = 32'h0000_000C;
  localparam logic [31:0] UART_RXDATA = 32'h0000_0010;

  localparam int STATUS_TX_BUSY  = 0;
  localparam int STATUS_RX_VALID = 1;

  localparam int CTRL_TX_EN = 0;

  typedef enum logic [4:0] {
    S_INIT   = 5'b00001,
    S_IDLE   = 5'b00010,
    S_POLL   = 5'b00100,
    S_SEND   = 5'b01000,
    S_SETTLE = 5'b10000
  } txq_state_t;

endpackage

// File: rtl/uart_txq_fifo.sv
// Byte FIFO with registered level/full/empty and a flush
// that wins over a same-cycle push.
module sync_fifo
  import uart_defs::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_level_nxt;

  assign w_push = push_i & ~r_full & ~flush_i;
  assign w_pop  = pop_i & ~r_empty;

  always_comb begin
    w_level_nxt = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + ONE_LVL;
      2'b01:   w_level_nxt = r_level - ONE_LVL;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == FULL_LVL);
      r_empty <= (w_level_nxt == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data_i;
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign level_o = r_level;
  assign full_o  = r_full;
  assign empty_o = r_empty;

endmodule

// File: rtl/uart_txq.sv
// UART transmit queue: enables the transmitter after reset, then
// drains buffered bytes by polling STATUS.busy and writing TXDATA.
module uart_txq
  import uart_defs::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4,
  parameter logic [31:0] INIT_CTRL = 32'h0000_0001
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic [7:0]    push_data_i,
  input  logic          flush_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic [15:0]   sent_cnt_o,
  output logic          uart_we_o,
  output logic [31:0]   uart_addr_o,
  output logic [31:0]   uart_data_o,
  input  logic [31:0]   uart_data_i
);

  txq_state_t  r_state;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [15:0] r_sent;

  logic [7:0]  w_head;
  logic        w_empty;
  logic        w_pop;
  logic        w_busy;

  assign w_pop  = (r_state == S_SEND);
  assign w_busy = uart_data_i[STATUS_TX_BUSY];

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .pop_i       (w_pop),
    .flush_i     (flush_i),
    .head_o      (w_head),
    .level_o     (level_o),
    .full_o      (full_o),
    .empty_o     (w_empty)
  );

  // Bus outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_INIT;
      r_we    <= 1'b1;
      r_addr  <= UART_CTRL;
      r_data  <= INIT_CTRL;
      r_sent  <= '0;
    end else begin
      unique case (r_state)
        S_INIT: begin
          r_state <= S_IDLE;
          r_we    <= 1'b0;
          r_addr  <= UART_STATUS;
          r_data  <= '0;
        end
        S_IDLE: begin
          if (!w_empty && !flush_i) begin
            r_state <= S_POLL;
          end
          r_we   <= 1'b0;
          r_addr <= UART_STATUS;
          r_data <= '0;
        end
        S_POLL: begin
          if (flush_i || w_empty) begin
            r_state <= S_IDLE;
          end else if (!w_busy) begin
            r_state <= S_SEND;
            r_we    <= 1'b1;
            r_addr  <= UART_TXDATA;
            r_data  <= {24'h0, w_head};
          end
        end
        S_SEND: begin
          r_state <= S_SETTLE;
          r_sent  <= r_sent + 16'd1;
          r_we    <= 1'b0;
          r_addr  <= UART_STATUS;
          r_data  <= '0;
        end
        S_SETTLE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_INIT;
          r_we    <= 1'b1;
          r_addr  <= UART_CTRL;
          r_data  <= INIT_CTRL;
        end
      endcase
    end
  end

  assign uart_we_o   = rstn & r_we;
  assign uart_addr_o = rstn ? r_addr : '0;
  assign uart_data_o = rstn ? r_data : '0;
  assign empty_o     = w_empty;
  assign sent_cnt_o  = r_sent;

endmodule

// File: doc/uart_txq.md
Name: uart_txq

Overview:
- Transmit queue that sits directly upstream of the UART peripheral and is the sole master of its register port.
- Buffers bytes pushed by the core or a debug agent in a DEPTH-entry FIFO.
- Enables the UART transmitter once after reset.
- Drains the queue by polling UART_STATUS.busy and writing UART_TXDATA, so software never spins on the busy bit.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AW, 4, log2(DEPTH); pointer width.
- INIT_CTRL, 32'h0000_0001, value written to UART_CTRL after reset (bit0 tx enable).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- push_i  in  1  enqueue strobe
- push_data_i  in  8  byte to enqueue
- flush_i  in  1  discard all queued bytes
- full_o  out  1  FIFO holds DEPTH entries
- empty_o  out  1  FIFO holds 0 entries
- level_o  out  AW+1  entries held
- sent_cnt_o  out  16  bytes handed to the UART; wraps modulo 2^16
- uart_we_o  out  1  UART register write enable
- uart_addr_o  out  32  UART register address
- uart_data_o  out  32  UART write data
- uart_data_i  in  32  UART read data; combinational from uart_addr_o, same cycle

Behaviour:
- Reset and clocking
  - Reset is rstn, synchronous, active-low; clock is clk.
  - Reset values: pointers 0, level_o 0, empty_o 1, full_o 0, sent_cnt_o 0, state S_INIT.
  - uart_we_o, uart_addr_o and uart_data_o are forced to 0 while rstn is low.
- Register map constants
  - CTRL 0x00, STATUS 0x04, TXDATA 0x0C.
  - STATUS bit0 is tx busy.
- FIFO
  - A push is accepted when push_i=1, full_o=0 and flush_i=0.
  - A push while full is dropped silently; there is no overwrite.
  - A pop occurs only in S_SEND.
  - A simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo DEPTH.
  - level_o, full_o and empty_o are registered and update the cycle after the event.
- Flush
  - Pointers and level are set to 0 next cycle.
  - Flush wins over a same-cycle push.
  - If the FSM is in S_SEND, that write still occurs: the byte is already on the bus and is counted.
- FSM outputs are a Moore decode of state:
  - S_INIT: we=1, addr=CTRL, data=INIT_CTRL. Next state S_IDLE. Occupies exactly one cycle after reset release.
  - S_IDLE: we=0, addr=STATUS. Go to S_POLL when empty_o=0 and flush_i=0.
  - S_POLL: we=0, addr=STATUS. If uart_data_i[0]=0 go to S_SEND; else stay. If the FIFO becomes empty (flush), return to S_IDLE.
  - S_SEND: we=1, addr=TXDATA, data={24'h0, fifo head}. Pop the head, increment sent_cnt_o, go to S_SETTLE.
  - S_SETTLE: we=0, addr=STATUS. One cycle so the UART latches busy=1 and drops its valid pulse. Go to S_IDLE.
- Timing
  - Minimum spacing between TXDATA writes is 4 cycles plus the UART busy time.
  - First write after a push into an empty queue: push at cycle t, empty_o low at t+1, S_POLL at t+2, S_SEND at t+3 if not busy.
- Reset mid-operation: state returns to S_INIT and the queue is lost. A frame already in the UART finishes independently.
- Width rule: level_o is AW+1 bits so that DEPTH is representable.

Decomposition:
- Shared package uart_defs:
  - UART_CTRL/STATUS/BAUD/TXDATA/RXDATA address constants
  - STATUS bit indices
  - state localparams S_INIT, S_IDLE, S_POLL, S_SEND, S_SETTLE, one-hot 5-bit
- One natural sub-module: sync_fifo (parameters DEPTH, WIDTH=8).
  - Ports: push/pop/flush, head data, level/full/empty.
  - The top holds only the FSM, counter and output decode.

Test Plan:
- Release reset -> the first cycle shows uart_we_o=1, uart_addr_o=0x00, uart_data_o=0x1, then we=0; the UART tx enable reads back 1.
- Push 0x55 into the idle queue with the UART idle -> TXDATA write with data 0x00000055 three cycles after the push; sent_cnt_o=1; empty_o=1; the UART tx pin shows a start bit followed by 10101010 LSB-first and a stop bit.
- Push 0x41,0x42,0x43 back-to-back -> level_o reaches 3; three TXDATA writes in order, each issued only after STATUS[0] reads 0; no write while busy; sent_cnt_o=3.
- Push 17 bytes with DEPTH=16 while the UART is busy -> full_o=1 after the 16th; the 17th is dropped; exactly 16 bytes are transmitted.
- Queue 5 bytes, assert flush_i during S_POLL -> level_o=0 next cycle; FSM returns to S_IDLE; no further TXDATA writes; push with flush in the same cycle is not enqueued.
- Assert rstn=0 for 1 cycle mid-queue with 4 bytes pending -> level_o=0, sent_cnt_o=0, S_INIT write repeated, queue empty.
